// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, execution-unit indices, error codes and
// the issue controller state type. Used by the opcode decoder and the issue side.
package alu_pkg;

    localparam int unsigned OP_W   = 4;
    localparam int unsigned UNIT_W = 7;
    localparam int unsigned ERR_W  = 2;

    localparam logic [OP_W-1:0] OP_AND  = 4'd0;
    localparam logic [OP_W-1:0] OP_OR   = 4'd1;
    localparam logic [OP_W-1:0] OP_XOR  = 4'd2;
    localparam logic [OP_W-1:0] OP_ADD  = 4'd3;
    localparam logic [OP_W-1:0] OP_INC  = 4'd4;
    localparam logic [OP_W-1:0] OP_SUB  = 4'd5;
    localparam logic [OP_W-1:0] OP_DEC  = 4'd6;
    localparam logic [OP_W-1:0] OP_SLL  = 4'd7;
    localparam logic [OP_W-1:0] OP_SRL  = 4'd8;
    localparam logic [OP_W-1:0] OP_SRA  = 4'd9;
    localparam logic [OP_W-1:0] OP_NONE = 4'hF;

    localparam int unsigned U_AND    = 0;
    localparam int unsigned U_OR     = 1;
    localparam int unsigned U_XOR    = 2;
    localparam int unsigned U_ADDSUB = 3;
    localparam int unsigned U_SLL    = 4;
    localparam int unsigned U_SRL    = 5;
    localparam int unsigned U_SRA    = 6;

    localparam logic [ERR_W-1:0] ERR_OK         = 2'b00;
    localparam logic [ERR_W-1:0] ERR_ILLEGAL    = 2'b01;
    localparam logic [ERR_W-1:0] ERR_TIMEOUT    = 2'b10;
    localparam logic [ERR_W-1:0] ERR_WRONG_UNIT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    function automatic logic [UNIT_W-1:0] unit_onehot(input int unsigned idx);
        return UNIT_W'(1) << idx;
    endfunction

endpackage

// File: rtl/alu_op_to_unit.sv
// Opcode to expected execution-unit one-hot. Same table the datapath decoder uses,
// so the issue side and the enable side cannot disagree on which unit owns an opcode.
module alu_op_to_unit
    import alu_pkg::*;
(
    input  logic [OP_W-1:0]   opcode_i,
    output logic [UNIT_W-1:0] unit_oh_c,
    output logic              illegal_c
);

    always_comb begin
        unit_oh_c = '0;
        illegal_c = 1'b0;
        case (opcode_i)
            OP_AND:                         unit_oh_c = unit_onehot(U_AND);
            OP_OR:                          unit_oh_c = unit_onehot(U_OR);
            OP_XOR:                         unit_oh_c = unit_onehot(U_XOR);
            OP_ADD, OP_INC, OP_SUB, OP_DEC: unit_oh_c = unit_onehot(U_ADDSUB);
            OP_SLL:                         unit_oh_c = unit_onehot(U_SLL);
            OP_SRL:                         unit_oh_c = unit_onehot(U_SRL);
            OP_SRA:                         unit_oh_c = unit_onehot(U_SRA);
            default:                        illegal_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU command issue controller: accepts a command, strobes the owning unit, waits for
// its one-hot done (with timeout), and returns result plus status over valid/ready.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_opcode,
    input  logic [WIDTH-1:0]  cmd_a,
    input  logic [WIDTH-1:0]  cmd_b,
    output logic [OP_W-1:0]   opcode_out,
    output logic [WIDTH-1:0]  op_a,
    output logic [WIDTH-1:0]  op_b,
    output logic              unit_start,
    input  logic [UNIT_W-1:0] unit_done,
    input  logic [WIDTH-1:0]  unit_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WIDTH-1:0]  rsp_result,
    output logic [ERR_W-1:0]  rsp_error
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OP_W-1:0]    opc_q, opc_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               start_q, start_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [OP_W-1:0]    opcode_out_q, opcode_out_d;

    logic [OP_W-1:0]    dec_opc_c;
    logic [UNIT_W-1:0]  exp_oh_c;
    logic               illegal_c;

    // In IDLE the incoming opcode is screened; afterwards the latched one selects the unit.
    assign dec_opc_c = (state_q == ST_IDLE) ? cmd_opcode : opc_q;

    alu_op_to_unit u_op_to_unit (
        .opcode_i  (dec_opc_c),
        .unit_oh_c (exp_oh_c),
        .illegal_c (illegal_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            opc_q        <= OP_NONE;
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            err_q        <= ERR_OK;
            cmd_ready_q  <= 1'b1;
            start_q      <= 1'b0;
            rsp_valid_q  <= 1'b0;
            opcode_out_q <= OP_NONE;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            opc_q        <= opc_d;
            a_q          <= a_d;
            b_q          <= b_d;
            res_q        <= res_d;
            err_q        <= err_d;
            cmd_ready_q  <= cmd_ready_d;
            start_q      <= start_d;
            rsp_valid_q  <= rsp_valid_d;
            opcode_out_q <= opcode_out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opc_d   = opc_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    opc_d = cmd_opcode;
                    a_d   = cmd_a;
                    b_d   = cmd_b;
                    if (illegal_c) begin
                        state_d = ST_RESP;
                        err_d   = ERR_ILLEGAL;
                        res_d   = '0;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (unit_done == exp_oh_c) begin
                    state_d = ST_RESP;
                    err_d   = ERR_OK;
                    res_d   = unit_result;
                end else if (unit_done != '0) begin
                    state_d = ST_RESP;
                    err_d   = ERR_WRONG_UNIT;
                    res_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_RESP;
                    err_d   = ERR_TIMEOUT;
                    res_d   = '0;
                end
            end
            ST_RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output flops are loaded from the next state so every port comes straight off a register.
    always_comb begin
        cmd_ready_d  = 1'b0;
        start_d      = 1'b0;
        rsp_valid_d  = 1'b0;
        opcode_out_d = OP_NONE;
        case (state_d)
            ST_IDLE:  cmd_ready_d = 1'b1;
            ST_ISSUE: begin
                start_d      = 1'b1;
                opcode_out_d = opc_d;
            end
            ST_WAIT:  opcode_out_d = opc_d;
            ST_RESP:  rsp_valid_d = 1'b1;
            default:  cmd_ready_d = 1'b0;
        endcase
    end

    assign cmd_ready  = cmd_ready_q;
    assign unit_start = start_q;
    assign rsp_valid  = rsp_valid_q;
    assign opcode_out = opcode_out_q;
    assign op_a       = a_q;
    assign op_b       = b_q;
    assign rsp_result = res_q;
    assign rsp_error  = err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed scenarios with literal expectations plus randomized
// traffic, all outputs compared every cycle against a transaction-timeline model.
module tb_alu_issue_ctrl;

    localparam int W  = 32;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [3:0]    cmd_opcode = 4'd0;
    logic [W-1:0]  cmd_a = '0;
    logic [W-1:0]  cmd_b = '0;
    logic [3:0]    opcode_out;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic          unit_start;
    logic [6:0]    unit_done = '0;
    logic [W-1:0]  unit_result = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [W-1:0]  rsp_result;
    logic [1:0]    rsp_error;

    int n_tests = 0;
    int n_fail  = 0;
    int n_starts = 0;

    alu_issue_ctrl #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_opcode  (cmd_opcode),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .opcode_out  (opcode_out),
        .op_a        (op_a),
        .op_b        (op_b),
        .unit_start  (unit_start),
        .unit_done   (unit_done),
        .unit_result (unit_result),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_error   (rsp_error)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [6:0] exp_oh(input logic [3:0] op);
        if (op <= 4'd2)      return 7'(1) << op;
        else if (op <= 4'd6) return 7'b0001000;
        else                 return 7'(1) << (op - 4'd3);
    endfunction

    // Transaction model: cycle index since acceptance and the cycle the response appears.
    logic          m_busy = 1'b0;
    int            m_cur  = 0;
    int            m_rsp  = -1;
    logic [3:0]    m_op   = 4'hF;
    logic [W-1:0]  m_a    = '0;
    logic [W-1:0]  m_b    = '0;
    logic [1:0]    m_err  = 2'b00;
    logic [W-1:0]  m_res  = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_cur  <= 0;
            m_rsp  <= -1;
            m_a    <= '0;
            m_b    <= '0;
        end else if (m_busy) begin
            if (m_rsp >= 0 && m_cur >= m_rsp) begin
                if (rsp_ready) m_busy <= 1'b0;
            end else if (m_cur >= 2) begin
                if (unit_done != 7'd0) begin
                    m_rsp <= m_cur + 1;
                    m_err <= (unit_done == exp_oh(m_op)) ? 2'b00 : 2'b11;
                    m_res <= (unit_done == exp_oh(m_op)) ? unit_result : '0;
                end else if (m_cur == TO + 1) begin
                    m_rsp <= m_cur + 1;
                    m_err <= 2'b10;
                    m_res <= '0;
                end
            end
            m_cur <= m_cur + 1;
        end else if (cmd_valid) begin
            m_busy <= 1'b1;
            m_cur  <= 1;
            m_op   <= cmd_opcode;
            m_a    <= cmd_a;
            m_b    <= cmd_b;
            if (cmd_opcode >= 4'd10) begin
                m_rsp <= 1;
                m_err <= 2'b01;
                m_res <= '0;
            end else begin
                m_rsp <= -1;
            end
        end
    end

    always @(negedge clk) begin : cmp_p
        logic rv;
        logic legal;
        rv    = m_busy && m_rsp >= 0 && m_cur >= m_rsp;
        legal = m_op < 4'd10;
        chk("cmd_ready", 64'(cmd_ready), 64'(!m_busy));
        chk("unit_start", 64'(unit_start), 64'(m_busy && legal && m_cur == 1));
        chk("opcode_out", 64'(opcode_out), 64'((m_busy && legal && !rv) ? m_op : 4'hF));
        chk("op_a", 64'(op_a), 64'(m_a));
        chk("op_b", 64'(op_b), 64'(m_b));
        chk("rsp_valid", 64'(rsp_valid), 64'(rv));
        if (rv) begin
            chk("rsp_result", 64'(rsp_result), 64'(m_res));
            chk("rsp_error", 64'(rsp_error), 64'(m_err));
        end
        if (unit_start === 1'b1) n_starts++;
    end

    // Called at the start of an IDLE cycle; done_at is the cycle index (accept = 0) of the done pulse.
    task automatic run_cmd(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input int done_at, input logic [6:0] dvec, input logic [W-1:0] dres,
                           input int bp, output int lat, output logic [1:0] err,
                           output logic [W-1:0] res);
        bit got;
        got = 1'b0;
        lat = -1;
        err = 2'bxx;
        res = 'x;
        cmd_valid   = 1'b1;
        cmd_opcode  = op;
        cmd_a       = a;
        cmd_b       = b;
        unit_done   = 7'($urandom);
        unit_result = $urandom;
        rsp_ready   = 1'b0;
        for (int cyc = 1; cyc <= 40 && !got; cyc++) begin
            @(posedge clk); #1;
            cmd_valid   = 1'b0;
            cmd_opcode  = 4'($urandom);
            cmd_a       = $urandom;
            cmd_b       = $urandom;
            unit_done   = (cyc == done_at) ? dvec : 7'd0;
            unit_result = (cyc == done_at) ? dres : W'($urandom);
            if (rsp_valid) begin
                got = 1'b1;
                lat = cyc;
                err = rsp_error;
                res = rsp_result;
            end
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL rsp_wait: no rsp_valid within 40 cycles for op %0d", op);
        end
        for (int k = 0; k < bp; k++) begin
            cmd_valid  = 1'b1;
            cmd_opcode = 4'($urandom_range(0, 9));
            rsp_ready  = 1'b0;
            @(posedge clk); #1;
            unit_done  = 7'd0;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        unit_done = 7'd0;
    endtask

    int          lat;
    logic [1:0]  err;
    logic [W-1:0] res;
    int          s0;

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        chk("rst_opcode_out", 64'(opcode_out), 64'(4'hF));
        chk("rst_unit_start", 64'(unit_start), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_result", 64'(rsp_result), 64'(0));
        chk("rst_rsp_error", 64'(rsp_error), 64'(0));
        chk("rst_op_a", 64'(op_a), 64'(0));
        @(negedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        s0 = n_starts;
        run_cmd(4'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 2, 7'b0000001, 32'hF000_F000, 0, lat, err, res);
        chk("and_lat", 64'(lat), 64'(3));
        chk("and_res", 64'(res), 64'(32'hF000_F000));
        chk("and_err", 64'(err), 64'(0));
        chk("and_starts", 64'(n_starts - s0), 64'(1));

        s0 = n_starts;
        run_cmd(4'd5, 32'd10, 32'd3, 5, 7'b0001000, 32'h0000_0007, 0, lat, err, res);
        chk("sub_lat", 64'(lat), 64'(6));
        chk("sub_res", 64'(res), 64'(7));
        chk("sub_err", 64'(err), 64'(0));
        chk("sub_starts", 64'(n_starts - s0), 64'(1));

        s0 = n_starts;
        run_cmd(4'd12, 32'h1, 32'h2, 2, 7'b0000001, 32'hDEAD, 0, lat, err, res);
        chk("ill_lat", 64'(lat), 64'(1));
        chk("ill_err", 64'(err), 64'(1));
        chk("ill_res", 64'(res), 64'(0));
        chk("ill_starts", 64'(n_starts - s0), 64'(0));

        run_cmd(4'd8, 32'h5, 32'h6, -1, 7'd0, 32'h0, 0, lat, err, res);
        chk("to_lat", 64'(lat), 64'(17));
        chk("to_err", 64'(err), 64'(2));
        chk("to_res", 64'(res), 64'(0));

        run_cmd(4'd7, 32'h5, 32'h6, 2, 7'b0100000, 32'hBEEF, 0, lat, err, res);
        chk("wrong_lat", 64'(lat), 64'(3));
        chk("wrong_err", 64'(err), 64'(3));
        chk("wrong_res", 64'(res), 64'(0));

        run_cmd(4'd0, 32'h5, 32'h6, 1, 7'b0000001, 32'h1234, 0, lat, err, res);
        chk("issue_pulse_lat", 64'(lat), 64'(17));
        chk("issue_pulse_err", 64'(err), 64'(2));

        run_cmd(4'd1, 32'hA, 32'hB, 2, 7'b0000010, 32'h0000_1234, 5, lat, err, res);
        chk("bp_lat", 64'(lat), 64'(3));
        chk("bp_res", 64'(res), 64'(32'h1234));
        chk("bp_err", 64'(err), 64'(0));

        // Reset while waiting on a unit, then a clean command afterwards.
        cmd_valid  = 1'b1;
        cmd_opcode = 4'd3;
        cmd_a      = 32'h1111_1111;
        cmd_b      = 32'h2222_2222;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'(1));
        chk("mid_rst_opcode_out", 64'(opcode_out), 64'(4'hF));
        chk("mid_rst_op_a", 64'(op_a), 64'(0));
        chk("mid_rst_rsp_result", 64'(rsp_result), 64'(0));
        chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
        @(negedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        run_cmd(4'd9, 32'h8000_0000, 32'h4, 3, 7'b1000000, 32'hF800_0000, 1, lat, err, res);
        chk("post_rst_lat", 64'(lat), 64'(4));
        chk("post_rst_res", 64'(res), 64'(32'hF800_0000));
        chk("post_rst_err", 64'(err), 64'(0));

        for (int i = 0; i < 250; i++) begin
            logic [3:0] op;
            logic [6:0] dv;
            int         r;
            int         gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                cmd_valid  = 1'b0;
                cmd_opcode = 4'($urandom);
                unit_done  = 7'($urandom);
                @(posedge clk); #1;
            end
            op = 4'($urandom_range(0, 11));
            r  = $urandom_range(0, 9);
            if (r < 6)      dv = exp_oh(op);
            else if (r < 8) dv = 7'(1) << $urandom_range(0, 6);
            else begin
                dv = 7'($urandom);
                if (dv == 7'd0) dv = 7'h7F;
            end
            run_cmd(op, $urandom, $urandom, $urandom_range(1, 18), dv, $urandom,
                    $urandom_range(0, 3), lat, err, res);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
